// File: rtl/dense_layer_engine_if.sv
// Control, weight-ROM and result-stream signals of dense_layer_engine.
// master = engine side, slave = environment (controller, ROM, consumer).
interface dense_layer_engine_if #(
    parameter int unsigned N_IN   = 42,
    parameter int unsigned N_OUT  = 24,
    parameter int unsigned W_DATA = 16,
    parameter int unsigned W_ADDR = 11
);
    localparam int unsigned W_IDX = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     start;
    logic [1:0]               act_sel;
    logic [N_IN*W_DATA-1:0]   in_vec;
    logic [W_ADDR-1:0]        rom_addr;
    logic                     rom_en;
    logic [7:0]               rom_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [W_DATA-1:0]        out_data;
    logic [W_IDX-1:0]         out_idx;
    logic                     busy;
    logic                     done;
    logic                     ovf;

    modport master (
        input  start, act_sel, in_vec, rom_data, out_ready,
        output rom_addr, rom_en, out_valid, out_data, out_idx, busy, done, ovf
    );

    modport slave (
        output start, act_sel, in_vec, rom_data, out_ready,
        input  rom_addr, rom_en, out_valid, out_data, out_idx, busy, done, ovf
    );
endinterface

// File: rtl/dense_layer_engine.sv
// Sequential fixed-point dense layer: one neuron at a time on a single MAC, int8 weights from ROM.
// Optional DENSE_ACC_SAT_EN: saturating accumulator with sticky ovf (otherwise wrap, ovf=0).
module dense_layer_engine #(
    parameter int unsigned N_IN   = 42,
    parameter int unsigned N_OUT  = 24,
    parameter int unsigned W_DATA = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned W_ACC  = 32,
    parameter int unsigned W_ADDR = 11
) (
    input logic                  clk,
    input logic                  rst_n,
    dense_layer_engine_if.master bus
);
    localparam int unsigned W_IDX     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned W_I       = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned W_PROD    = W_DATA + 8;
    localparam int unsigned W_RND     = W_ACC + 1;
    localparam int unsigned W_HS      = W_DATA + 1;
    localparam int unsigned W_SCALE   = 8;
    localparam int unsigned RND_HALF  = 128;
    localparam int unsigned BIAS_BASE = N_IN * N_OUT;

    localparam logic signed [W_RND-1:0]  D_MAX   = W_RND'({1'b0, {(W_DATA-1){1'b1}}});
    localparam logic signed [W_RND-1:0]  D_MIN   = W_RND'($signed({1'b1, {(W_DATA-1){1'b0}}}));
    localparam logic signed [W_DATA-1:0] ONE_D   = W_DATA'(2**FRAC);
    localparam logic signed [W_DATA-1:0] NEG_ONE = -ONE_D;
    localparam logic signed [W_HS-1:0]   ONE_HS  = W_HS'(2**FRAC);
    localparam logic signed [W_HS-1:0]   HALF_HS = W_HS'(2**(FRAC-1));

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [N_IN*W_DATA-1:0]  x_q, x_d;
    logic [1:0]              act_q, act_d;
    logic [W_I-1:0]          i_q, i_d;
    logic [W_IDX-1:0]        n_q, n_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    rd_bias_q, rd_bias_d;
    logic [W_I-1:0]          rd_idx_q, rd_idx_d;
    logic signed [W_ACC-1:0] acc_q, acc_d;
    logic [W_ADDR-1:0]       rom_addr_q, rom_addr_d;
    logic                    rom_en_q, rom_en_d;
    logic                    out_valid_q, out_valid_d;
    logic [W_DATA-1:0]       out_data_q, out_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic signed [W_DATA-1:0] x_sel;
    logic signed [W_PROD-1:0] prod;
    logic signed [W_ACC-1:0]  term;
    logic signed [W_ACC-1:0]  acc_nx;
    logic signed [W_RND-1:0]  rnd;
    logic signed [W_RND-1:0]  v_wide;
    logic signed [W_DATA-1:0] v_sat;
    logic signed [W_HS-1:0]   hs;
    logic signed [W_DATA-1:0] act_out;

`ifdef DENSE_ACC_SAT_EN
    localparam int unsigned W_SUM = W_ACC + 1;
    localparam logic signed [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};
    logic signed [W_SUM-1:0] sum;
    logic                    clamp;
`endif

    // Accumulate the ROM byte that returns this cycle, then round/saturate/activate.
    always_comb begin
        x_sel = $signed(x_q[rd_idx_q*W_DATA +: W_DATA]);
        prod  = W_PROD'($signed(bus.rom_data)) * W_PROD'(x_sel);
        term  = rd_bias_q ? (W_ACC'($signed(bus.rom_data)) <<< FRAC) : W_ACC'(prod);
`ifdef DENSE_ACC_SAT_EN
        sum   = W_SUM'(acc_q) + W_SUM'(term);
        clamp = (sum[W_ACC] != sum[W_ACC-1]);
        if (clamp) acc_nx = sum[W_ACC] ? ACC_MIN : ACC_MAX;
        else       acc_nx = sum[W_ACC-1:0];
`else
        acc_nx = acc_q + term;
`endif
        // Weights carry 8 fractional bits on top of the shared Q format.
        rnd    = W_RND'(acc_nx) + $signed(W_RND'(RND_HALF));
        v_wide = rnd >>> W_SCALE;
        if (v_wide > D_MAX)      v_sat = W_DATA'(D_MAX);
        else if (v_wide < D_MIN) v_sat = W_DATA'(D_MIN);
        else                     v_sat = W_DATA'(v_wide);
        hs = W_HS'(v_sat >>> 2) + HALF_HS;
        case (act_q)
            2'd1:    act_out = v_sat[W_DATA-1] ? '0 : v_sat;
            2'd2:    act_out = (v_sat > ONE_D) ? ONE_D : ((v_sat < NEG_ONE) ? NEG_ONE : v_sat);
            2'd3:    act_out = hs[W_HS-1] ? '0 : ((hs > ONE_HS) ? ONE_D : W_DATA'(hs));
            default: act_out = v_sat;
        endcase
    end

    // Sequencing: bias fetch, N_IN weight fetches, drain, result handshake.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        act_d      = act_q;
        i_d        = i_q;
        n_d        = n_q;
        acc_d      = rd_vld_q ? acc_nx : acc_q;
        out_data_d = out_data_q;
        rd_vld_d   = rom_en_q;
        rd_bias_d  = (state_q == S_BIAS);
        rd_idx_d   = i_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                x_d     = bus.in_vec;
                act_d   = bus.act_sel;
                n_d     = '0;
                state_d = S_BIAS;
            end
            S_BIAS: begin
                acc_d   = '0;
                i_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (i_q == W_I'(N_IN - 1)) state_d = S_DRAIN;
                else                       i_d = i_q + W_I'(1);
            end
            S_DRAIN: begin
                out_data_d = act_out;
                state_d    = S_OUT;
            end
            S_OUT: if (bus.out_ready) begin
                if (n_q == W_IDX'(N_OUT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + W_IDX'(1);
                    state_d = S_BIAS;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        rom_en_d    = (state_d == S_BIAS) || (state_d == S_MAC);
        rom_addr_d  = '0;
        if (state_d == S_BIAS)     rom_addr_d = W_ADDR'(BIAS_BASE + n_d);
        else if (state_d == S_MAC) rom_addr_d = W_ADDR'(i_d * N_OUT + n_d);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            act_q       <= '0;
            i_q         <= '0;
            n_q         <= '0;
            rd_vld_q    <= 1'b0;
            rd_bias_q   <= 1'b0;
            rd_idx_q    <= '0;
            acc_q       <= '0;
            rom_addr_q  <= '0;
            rom_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            act_q       <= act_d;
            i_q         <= i_d;
            n_q         <= n_d;
            rd_vld_q    <= rd_vld_d;
            rd_bias_q   <= rd_bias_d;
            rd_idx_q    <= rd_idx_d;
            acc_q       <= acc_d;
            rom_addr_q  <= rom_addr_d;
            rom_en_q    <= rom_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef DENSE_ACC_SAT_EN
    logic ovf_q, ovf_d;

    // Sticky clamp flag, cleared when a new layer is accepted.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_IDLE && bus.start) ovf_d = 1'b0;
        else if (rd_vld_q && clamp)         ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_en    = rom_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
